// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants and state encoding for the 4-way round-robin
//               arbiter (rr_arb_4x2) and its priority picker (rr_pick4).
//   NREQ   - number of requesters (4)
//   IDX_W  - width of an encoded requester index (2)
//   arb_state_e - arbiter FSM states: IDLE (no owner), GRANT (one owner)
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational rotating-priority search. Scans req starting at
//               position ptr and wrapping modulo 4; reports the first set bit.
// Ports       :
//   req  [3:0] in  - request vector
//   ptr  [1:0] in  - highest-priority position for this search
//   hit        out - at least one request bit is set
//   idx  [1:0] out - index of the winning requester (0 when hit=0)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      // 2-bit addition wraps naturally, giving the modulo-4 scan order.
      cand = ptr + IDX_W'(k);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_arb_4x2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_4x2
// Description : 4-requester round-robin arbiter with registered one-hot grant.
//               An owner keeps the grant while en=1 and its request stays
//               high; each release costs one dead (IDLE) cycle.
// Parameters  :
//   MAX_HOLD   - max consecutive grant cycles per owner (1..255); only used
//                when the macro ARB_TIMEOUT_EN is defined.
// Macro       : ARB_TIMEOUT_EN - enables the hold counter / grant timeout.
// Ports       :
//   clk            in  - rising-edge clock
//   rst_n          in  - asynchronous active-low reset
//   en             in  - arbiter enable (low revokes / blocks grants)
//   req     [3:0]  in  - request per requester
//   gnt     [3:0]  out - one-hot grant (registered)
//   gnt_idx [1:0]  out - encoded owner (registered, 0 when no owner)
//   gnt_vld        out - grant valid (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_4x2
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [NREQ-1:0]  gnt_q,   gnt_d;
  logic             vld_q,   vld_d;

  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;
  logic             timeout;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  // Counter holds (cycles already spent in GRANT - 1); reaching MAX_HOLD-1
  // means the current cycle is the MAX_HOLD-th grant cycle.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  assign timeout = (hold_cnt_q == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      vld_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      vld_q      <= vld_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (en && pick_hit) begin
          state_d = GRANT;
          owner_d = pick_idx;
          ptr_d   = pick_idx + 1'b1;   // wraps 3 -> 0
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (!en || !req[owner_q] || timeout) begin
          state_d = IDLE;
          owner_d = '0;                // gnt_idx reads 0 while no owner
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase

    // Grant outputs are derived from the next state so they register
    // together with it and can never disagree.
    vld_d = (state_d == GRANT);
    gnt_d = vld_d ? (NREQ'(1) << owner_d) : '0;
  end

  assign gnt     = gnt_q;
  assign gnt_idx = owner_q;
  assign gnt_vld = vld_q;

endmodule : rr_arb_4x2
`default_nettype wire

// File: tb/tb_rr_arb_4x2.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_4x2
// Description : Directed self-checking bench for rr_arb_4x2. Expected grant
//               values are queued when each stimulus step is driven and
//               popped when the registered outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_4x2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;

  int pass_cnt;
  int total_cnt;

  // Packed expectation: {gnt[3:0], gnt_idx[1:0], gnt_vld}
  logic [6:0] exp_q[$];

  rr_arb_4x2 #(.MAX_HOLD(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] own(input int i);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    return {oh, 2'(i), 1'b1};
  endfunction

  localparam logic [6:0] NONE = 7'b0;

  task automatic chk(input string tag);
    logic [6:0] obs;
    logic [6:0] exp;
    logic [3:0] oh;
    obs = {gnt, gnt_idx, gnt_vld};
    if (exp_q.size() == 0) begin
      total_cnt++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed gnt=%b idx=%0d vld=%b expected gnt=%b idx=%0d vld=%b",
                  tag, obs[6:3], obs[2:1], obs[0], exp[6:3], exp[2:1], exp[0]);
    end
    // Output consistency: gnt equals 1<<gnt_idx when valid, else all zero.
    oh = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
    total_cnt++;
    assert (gnt === oh) pass_cnt++;
    else $error("FAIL %s_consistency: observed gnt=%b expected gnt=%b", tag, gnt, oh);
  endtask

  task automatic step(input logic e, input logic [3:0] r, input logic [6:0] exp,
                      input string tag);
    @(negedge clk);
    en  = e;
    req = r;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    #1;
    exp_q.push_back(NONE);
    chk(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b1;
    en    = 1'b0;
    req   = 4'b0000;

    // Basic grant and release.
    do_reset("reset_a");
    step(1'b1, 4'b0100, own(2), "basic_grant2");
    step(1'b1, 4'b0000, NONE,   "basic_release");

    // Fairness rotation with one dead cycle between grants.
    do_reset("reset_b");
    step(1'b1, 4'b1111, own(0), "rot_g0");
    step(1'b1, 4'b1111, own(0), "rot_hold0");
    step(1'b1, 4'b1110, NONE,   "rot_dead0");
    step(1'b1, 4'b1111, own(1), "rot_g1");
    step(1'b1, 4'b1101, NONE,   "rot_dead1");
    step(1'b1, 4'b1111, own(2), "rot_g2");
    step(1'b1, 4'b1011, NONE,   "rot_dead2");
    step(1'b1, 4'b1111, own(3), "rot_g3");
    step(1'b1, 4'b0111, NONE,   "rot_dead3");
    step(1'b1, 4'b1111, own(0), "rot_g0_again");

    // Enable gating.
    do_reset("reset_c");
    step(1'b0, 4'b0010, NONE,   "en_off_a");
    step(1'b0, 4'b0010, NONE,   "en_off_b");
    step(1'b1, 4'b0010, own(1), "en_on_g1");
    step(1'b1, 4'b0010, own(1), "en_hold1");
    step(1'b0, 4'b0010, NONE,   "en_revoke");
    step(1'b1, 4'b0010, own(1), "en_regrant1");
    step(1'b0, 4'b0000, NONE,   "en_req_drop_same");
    step(1'b1, 4'b0000, NONE,   "idle_no_req");

    // Hold limit.
    do_reset("reset_d");
    step(1'b1, 4'b1001, own(0), "hold_c1");
    step(1'b1, 4'b1001, own(0), "hold_c2");
    step(1'b1, 4'b1001, own(0), "hold_c3");
`ifdef ARB_TIMEOUT_EN
    step(1'b1, 4'b1001, NONE,   "timeout_dead");
    step(1'b1, 4'b1001, own(3), "timeout_g3");
`else
    step(1'b1, 4'b1001, own(0), "hold_c4");
    step(1'b1, 4'b1001, own(0), "hold_c5");
    step(1'b1, 4'b1001, own(0), "hold_c6");
`endif

    // Asynchronous reset mid-grant.
    do_reset("reset_e");
    step(1'b1, 4'b0100, own(2), "ar_g2");
    step(1'b1, 4'b0100, own(2), "ar_hold2");
    #2;                       // mid-cycle, away from any clock edge
    rst_n = 1'b0;
    #1;
    exp_q.push_back(NONE);
    chk("async_reset_drop");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'b1100, own(2), "ar_after_ptr0");

    // Pointer wrap 3 -> 0.
    do_reset("reset_f");
    step(1'b1, 4'b1000, own(3), "wrap_g3");
    step(1'b1, 4'b0000, NONE,   "wrap_release");
    step(1'b1, 4'b1001, own(0), "wrap_g0");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_rr_arb_4x2
`default_nettype wire
